// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges pipeline writeback with queued MDU results and
// exposes a busy scoreboard. Optional write tracing under GRF_WB_TRACE_EN.
`timescale 1ns/1ps
module grf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        RegWrite,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic [31:0] PC,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic        stall_req
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ZERO_CNT   = {(PW+1){1'b0}};
  localparam logic [PW:0]   ONE_CNT    = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_PTR    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

  logic [4:0]    addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic [7:0]    starve_cnt_r;

  logic          wb_sel_s;
  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [PW:0]   count_next_s;
  logic [7:0]    starve_next_s;

  // An entry is live when its distance from the read pointer is below the fill count.
  function automatic logic slot_live(input logic [PW-1:0] idx,
                                     input logic [PW-1:0] rd,
                                     input logic [PW:0]   cnt);
    logic [PW-1:0] off;
    off = idx - rd;
    return ({1'b0, off} < cnt);
  endfunction

  // Handshake, arbitration decision and next fill count.
  always_comb begin
    md_ready     = (count_r != FULL_CNT);
    wb_sel_s     = wb_we && (wb_addr != 5'd0);
    push_s       = md_valid && md_ready && (md_addr != 5'd0);
    fifo_empty_s = (count_r == ZERO_CNT);
    pop_s        = !wb_sel_s && !fifo_empty_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_CNT;
      2'b01:   count_next_s = count_r - ONE_CNT;
      default: count_next_s = count_r;
    endcase
  end

  // Starvation counter: runs while entries wait without draining, saturating.
  always_comb begin
    starve_next_s = starve_cnt_r;
    if (fifo_empty_s || pop_s) begin
      starve_next_s = 8'd0;
    end else if (starve_cnt_r != STARVE_LIM) begin
      starve_next_s = starve_cnt_r + 8'd1;
    end else begin
      starve_next_s = starve_cnt_r;
    end
  end

  // Scoreboard lookup; the output stage is excluded since the GRF bypass covers it.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy1 = busy1 | (slot_live(PW'(i), rd_ptr_r, count_r) &&
                       (addr_mem_r[i] == chk_addr1) && (chk_addr1 != 5'd0));
      busy2 = busy2 | (slot_live(PW'(i), rd_ptr_r, count_r) &&
                       (addr_mem_r[i] == chk_addr2) && (chk_addr2 != 5'd0));
    end
  end

  // MDU result FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_CNT;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 5'd0;
        data_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= 32'd0;
      end
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= md_addr;
        data_mem_r[wr_ptr_r] <= md_data;
        pc_mem_r[wr_ptr_r]   <= md_pc;
        wr_ptr_r             <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      count_r <= count_next_s;
    end
  end

  // GRF write port register; address/data/pc hold when no write is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite <= 1'b0;
      WA       <= 5'd0;
      WD       <= 32'd0;
      PC       <= 32'd0;
    end else if (wb_sel_s) begin
      RegWrite <= 1'b1;
      WA       <= wb_addr;
      WD       <= wb_data;
      PC       <= wb_pc;
    end else if (pop_s) begin
      RegWrite <= 1'b1;
      WA       <= addr_mem_r[rd_ptr_r];
      WD       <= data_mem_r[rd_ptr_r];
      PC       <= pc_mem_r[rd_ptr_r];
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // Starvation counter and stall request, kept aligned so stall drops on the draining edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= 8'd0;
      stall_req    <= 1'b0;
    end else begin
      starve_cnt_r <= starve_next_s;
      stall_req    <= (starve_next_s == STARVE_LIM);
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Trace each GRF write as it is loaded into the output register.
  always_ff @(posedge clk) begin
    if (reset_n && wb_sel_s) begin
      $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
    end else if (reset_n && pop_s) begin
      $display("%d@%h: $%d <= %h", $time, pc_mem_r[rd_ptr_r],
               addr_mem_r[rd_ptr_r], data_mem_r[rd_ptr_r]);
    end else begin
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_grf_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_we, md_valid, md_ready, RegWrite, busy1, busy2, stall_req;
  logic [4:0]  wb_addr, md_addr, WA, chk_addr1, chk_addr2;
  logic [31:0] wb_data, wb_pc, md_data, md_pc, WD, PC;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr),
    .md_data(md_data), .md_pc(md_pc),
    .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2), .stall_req(stall_req)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        q[$];
  logic        e_rw;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_pc;
  int          starve;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic model_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    e_rw = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_pc = 32'd0; starve = 0;
  endtask

  task automatic check_all();
    check_eq("RegWrite", 32'(RegWrite), 32'(e_rw));
    check_eq("WA", 32'(WA), 32'(e_wa));
    check_eq("WD", WD, e_wd);
    check_eq("PC", PC, e_pc);
    check_eq("md_ready", 32'(md_ready), 32'(q.size() != DEPTH));
    check_eq("busy1", 32'(busy1), 32'(model_busy(chk_addr1)));
    check_eq("busy2", 32'(busy2), 32'(model_busy(chk_addr2)));
    check_eq("stall_req", 32'(stall_req), 32'(starve == STARVE_MAX));
  endtask

  // Apply the arbitration rules to the current inputs for one rising edge.
  task automatic model_step();
    bit   nonempty, wbsel, acc, pop;
    ent_t h;
    nonempty = (q.size() > 0);
    acc      = md_valid && (q.size() != DEPTH);
    wbsel    = wb_we && (wb_addr != 5'd0);
    pop      = !wbsel && nonempty;
    if (wbsel) begin
      e_rw = 1'b1; e_wa = wb_addr; e_wd = wb_data; e_pc = wb_pc;
    end else if (pop) begin
      h = q.pop_front();
      e_rw = 1'b1; e_wa = h.a; e_wd = h.d; e_pc = h.p;
    end else begin
      e_rw = 1'b0;
    end
    if (acc && md_addr != 5'd0) q.push_back('{md_addr, md_data, md_pc});
    if (!nonempty || pop) starve = 0;
    else if (starve < STARVE_MAX) starve++;
  endtask

  task automatic step();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;
    md_valid = 1'b0; md_addr = 5'd0; md_data = 32'd0; md_pc = 32'd0;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    @(negedge clk);

    // Pipeline write, then a write to $0.
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678; wb_pc = 32'h0000_3000;
    step();
    #1;
    check_eq("wb_regwrite", 32'(RegWrite), 32'd1);
    check_eq("wb_wa", 32'(WA), 32'd5);
    check_eq("wb_wd", WD, 32'h12345678);
    check_eq("wb_pc", PC, 32'h0000_3000);
    wb_addr = 5'd0;
    step();
    #1;
    check_eq("wb_zero_regwrite", 32'(RegWrite), 32'd0);

    // Single MDU result drains through an idle slot.
    idle();
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hDEAD0001; md_pc = 32'h0000_4000;
    chk_addr1 = 5'd8;
    step();
    md_valid = 1'b0;
    #1;
    check_eq("md_busy_after_push", 32'(busy1), 32'd1);
    step();
    #1;
    check_eq("md_pop_regwrite", 32'(RegWrite), 32'd1);
    check_eq("md_pop_wa", 32'(WA), 32'd8);
    check_eq("md_busy_after_pop", 32'(busy1), 32'd0);

    // Fill the FIFO while writeback occupies the port, then drain in order.
    idle();
    wb_we = 1'b1; wb_addr = 5'd3;
    for (int i = 0; i < 4; i++) begin
      md_valid = 1'b1; md_addr = 5'(10 + i); md_data = 32'hA000_0000 + i; md_pc = 32'h100 + 4 * i;
      step();
    end
    md_valid = 1'b0;
    #1;
    check_eq("full_md_ready", 32'(md_ready), 32'd0);
    wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check_eq("drain_order_wa", 32'(WA), 32'(10 + i));
    end

    // Starvation: one entry held back by continuous writeback.
    wb_we = 1'b1; wb_addr = 5'd3;
    md_valid = 1'b1; md_addr = 5'd20; md_data = 32'hBEEF_0020; md_pc = 32'h200;
    step();
    md_valid = 1'b0;
    repeat (7) step();
    #1;
    check_eq("starve_before_limit", 32'(stall_req), 32'd0);
    step();
    #1;
    check_eq("starve_at_limit", 32'(stall_req), 32'd1);
    wb_we = 1'b0;
    step();
    #1;
    check_eq("starve_cleared", 32'(stall_req), 32'd0);
    check_eq("starve_pop_wa", 32'(WA), 32'd20);

    // MDU result to $0 is accepted and dropped.
    idle();
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h5555_5555;
    #1;
    check_eq("zero_md_ready", 32'(md_ready), 32'd1);
    step();
    md_valid = 1'b0;
    step();
    #1;
    check_eq("zero_no_write", 32'(RegWrite), 32'd0);

    // Randomized traffic with phases of increasing writeback pressure.
    for (int c = 0; c < 3000; c++) begin
      int pct;
      pct = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 60 : 95);
      wb_we    = ($urandom_range(99) < pct);
      wb_addr  = ($urandom_range(31) == 0) ? 5'd0 : 5'($urandom);
      wb_data  = $urandom;
      wb_pc    = $urandom;
      md_valid = $urandom_range(1);
      md_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      md_data  = $urandom;
      md_pc    = $urandom;
      chk_addr1 = (q.size() > 0 && $urandom_range(1) == 1) ? q[$urandom_range(q.size() - 1)].a : 5'($urandom);
      chk_addr2 = 5'($urandom);
      step();
    end

    // Asynchronous reset with three queued entries.
    idle();
    wb_we = 1'b1; wb_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_addr = 5'(17 + i); md_data = $urandom; md_pc = $urandom;
      step();
    end
    md_valid = 1'b0;
    chk_addr1 = 5'd17; chk_addr2 = 5'd19;
    #1;
    check_eq("pre_reset_busy", 32'(busy1), 32'd1);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_md_ready", 32'(md_ready), 32'd1);
    check_eq("async_busy1", 32'(busy1), 32'd0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Write-side front end of the general register file. It merges the pipeline writeback stream with results from the multi-cycle multiply/divide unit into the GRF's single write port (RegWrite/WA/WD).
- MDU results are buffered in a small FIFO and drained into idle writeback slots.
- Exposes a busy scoreboard so the decode stage can stall on registers with queued writes.

Parameters:
- DEPTH, 4, MDU result FIFO entries; power of two, 2..16
- STARVE_MAX, 8, consecutive blocked-drain cycles before stall_req asserts; 1..255

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wb_we  in  1  pipeline writeback enable; always accepted, no handshake
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_pc  in  32  PC of the writing instruction
- md_valid  in  1  MDU result valid
- md_ready  out  1  arbiter can accept an MDU result
- md_addr  in  5  MDU destination register
- md_data  in  32  MDU result
- md_pc  in  32  PC of the MDU instruction
- RegWrite  out  1  GRF write enable (registered)
- WA  out  5  GRF write address (registered)
- WD  out  32  GRF write data (registered)
- PC  out  32  PC for the GRF write (registered)
- chk_addr1  in  5  decode query address 1
- chk_addr2  in  5  decode query address 2
- busy1  out  1  chk_addr1 has a queued write
- busy2  out  1  chk_addr2 has a queued write
- stall_req  out  1  request to upstream to bubble wb_we

Behaviour:
- Reset (reset_n low, asynchronous): RegWrite=0, WA=0, WD=0, PC=0, FIFO emptied, starve counter=0, stall_req=0. Combinational outputs then read md_ready=1 and busy1=busy2=0.
- Reset mid-operation discards all queued MDU results and any in-flight output.
- md_ready = (count != DEPTH). It depends on registered count only; there is no same-cycle pass-through when full.
- Handshake: an MDU result is accepted on a rising edge with md_valid && md_ready.
  - If md_addr != 0, it is pushed.
  - If md_addr == 0, it is accepted and discarded (no push).
- Output selection at each rising edge, using start-of-cycle state:
  1. wb_we && wb_addr != 0: drive RegWrite=1, WA/WD/PC from wb_* in the next cycle.
  2. Else if FIFO is non-empty: pop the head and drive RegWrite=1 with its addr/data/pc.
  3. Else: RegWrite=0. WA/WD/PC hold their previous values.
- wb_we with wb_addr == 0 counts as no write; the FIFO may drain in that slot.
- Latency:
  - Pipeline write: 1 cycle to RegWrite.
  - MDU write: minimum 2 cycles (push edge, then pop edge).
- Push and pop in the same edge are allowed. Count is unchanged; a push into an empty FIFO cannot pop in the same edge.
- FIFO order is strict FIFO; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- busyN = OR over valid FIFO entries of (entry.addr == chk_addrN), forced to 0 when chk_addrN == 0. It is combinational.
- busyN excludes the output stage, because the GRF's internal bypass covers that write.
- Starve counter:
  - Increments on each edge where the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- stall_req = (counter == STARVE_MAX), registered.
- Upstream contract: upstream must deassert wb_we in the cycle after stall_req is seen. The arbiter still gives wb_we priority if upstream violates this.

Optional Feature:
- Macro: GRF_WB_TRACE_EN.
- Defined: on every edge that loads RegWrite=1, print via $display "%d@%h: $%d <= %h" with $time, PC, WA, WD of the new write, in simulation only.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Reset → RegWrite=0, WA=0, WD=0, PC=0, md_ready=1, busy1=busy2=0, stall_req=0. Assert reset_n low mid-queue with 3 entries → FIFO empty and md_ready=1 immediately, without waiting for a clock.
- wb_we=1, wb_addr=5, wb_data=0x12345678, wb_pc=0x3000 → next cycle RegWrite=1, WA=5, WD=0x12345678, PC=0x3000. Same with wb_addr=0 → RegWrite=0.
- md_valid with addr=8, data=0xDEAD0001 while wb_we idle → busy1=1 for chk_addr1=8 one cycle after the push edge. RegWrite=1, WA=8 on the following cycle, then busy1=0.
- Hold wb_we=1 (addr 3) while pushing 4 MDU results → md_ready=0 after 4 accepts. Drop wb_we → entries drain in push order, one per cycle.
- One queued entry with wb_we held high → stall_req=1 after STARVE_MAX=8 blocked cycles. Drop wb_we → entry pops and stall_req clears on the next edge.
- MDU result to register 0 → handshake completes, no push, no GRF write, busy stays 0.
